// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner and single-outstanding fetch stage; define IFETCH_ADEL_EN to report misaligned redirect targets as id_adel
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic        id_adel,
  input  logic        id_ready,
  input  logic        id_jump,
  input  logic [31:0] id_jump_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target
);
`ifdef IFETCH_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, id_ins_q, id_ins_d, id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d, id_adel_q, id_adel_d;
  logic        flush, misal, room;
  logic [31:0] target_raw, target;
  always_comb begin
    flush      = ex_redirect | id_jump;
    target_raw = ex_redirect ? ex_target : id_jump_pc;
    target     = ADEL ? target_raw : {target_raw[31:2], 2'b00};
    misal      = ADEL && (pc_q[1:0] != 2'b00);
    room       = !id_valid_q | id_ready;
    imem_req   = !rst && (state_q == S_REQ) && !flush && room && !misal;
    imem_addr  = {pc_q[31:2], 2'b00};
    state_d    = state_q;
    pc_d       = flush ? target : pc_q;
    id_valid_d = id_valid_q & !id_ready & !flush;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    id_adel_d  = id_adel_q;
    case (state_q)
      S_REQ: begin
        if (flush) state_d = imem_gnt ? S_DROP : S_REQ;
        else if (misal && room) begin
          id_valid_d = 1'b1;
          id_adel_d  = 1'b1;
          id_ins_d   = 32'h0;
          id_pc_d    = pc_q + 32'd4;
          state_d    = S_HALT;
        end else if (imem_req && imem_gnt) begin
          state_d = S_WAIT;
          pc_d    = pc_q + 32'd4;
        end
      end
      // pc_q already points past the outstanding word, so it is the id_pc to deliver
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (!flush) begin
            id_valid_d = 1'b1;
            id_adel_d  = 1'b0;
            id_ins_d   = imem_rdata;
            id_pc_d    = pc_q;
          end
        end else if (flush) state_d = S_DROP;
      end
      S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
      default: state_d = flush ? S_REQ : S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_ins_q   <= 32'h0;
      id_pc_q    <= 32'h0;
      id_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
      id_adel_q  <= id_adel_d;
    end
  end
  assign id_valid = id_valid_q;
  assign id_ins   = id_ins_q;
  assign id_pc    = id_pc_q;
  assign id_adel  = id_adel_q;
endmodule
